// File: rtl/seven_seg_pkg.sv
// Shared segment types, blank pattern and BCD-to-segment decode for the seven-segment scanner.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Segment order is {a,b,c,d,e,f,g}, active-low; non-BCD codes show nothing.
    function automatic seg_t seg_decode(input logic [3:0] bcd);
        seg_t s;
        case (bcd)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD nibble to active-low segment pattern.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = seg_decode(nibble);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver with a frame-aligned pending/active double buffer.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZ_BLANK_EN.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic                  load_ack,
    output seg_t                  seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  frame;
    logic                  swap;

    logic [4*N_DIGITS-1:0] pend_val;
    logic [N_DIGITS-1:0]   pend_dp;
    logic                  pend_vld;
    logic [4*N_DIGITS-1:0] act_val;
    logic [N_DIGITS-1:0]   act_dp;

    logic [3:0]            nibble;
    logic                  dp_sel;
    logic                  blank_sel;
    logic [N_DIGITS-1:0]   an_next;
    seg_t                  dec_seg;

    assign tick  = en && (cnt == CNT_LAST);
    assign frame = tick && (idx == IDX_LAST);
    assign swap  = frame && (load || pend_vld);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A load landing on the boundary bypasses pending so it is never lost or delayed a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
            act_val  <= '0;
            act_dp   <= '0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= swap;
            if (frame && load) begin
                act_val  <= value;
                act_dp   <= dp_in;
                pend_vld <= 1'b0;
            end else if (frame && pend_vld) begin
                act_val  <= pend_val;
                act_dp   <= pend_dp;
                pend_vld <= 1'b0;
            end else if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_vld <= 1'b1;
            end
        end
    end

    always_comb begin
        nibble  = '0;
        dp_sel  = 1'b0;
        an_next = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nibble     = act_val[4*i +: 4];
                dp_sel     = act_dp[i];
                an_next[i] = 1'b0;
            end
        end
    end

`ifdef SEVSEG_LZ_BLANK_EN
    logic [N_DIGITS-1:0] keep;

    // Scan from the top: a digit is kept once any nonzero nibble at or above it is seen.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        keep      = '0;
        blank_sel = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (|act_val[4*i +: 4]);
            keep[i] = seen || (i == 0);
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                blank_sel = !keep[i];
            end
        end
    end
`else
    assign blank_sel = 1'b0;
`endif

    seven_seg_decode u_decode (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else if (en) begin
            seg <= blank_sel ? SEG_BLANK : dec_seg;
            dp  <= ~dp_sel;
            an  <= an_next;
        end else begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a time-based reference model queues the expected outputs per clock.
module tb_seven_seg_scan;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load_ack;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .N_DIGITS    (N),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .load_ack (load_ack),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    // Model: t counts enabled cycles since reset, so slot and frame position are plain arithmetic.
    int          t;
    logic [15:0] act_v, pend_v;
    logic [3:0]  act_dp, pend_dp;
    logic        pend_vld;
    logic [6:0]  dec_tab [16];

    initial begin
        dec_tab[0]  = 7'b0000001; dec_tab[1]  = 7'b1001111;
        dec_tab[2]  = 7'b0010010; dec_tab[3]  = 7'b0000110;
        dec_tab[4]  = 7'b1001100; dec_tab[5]  = 7'b0100100;
        dec_tab[6]  = 7'b0100000; dec_tab[7]  = 7'b0001111;
        dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0000100;
        for (int i = 10; i < 16; i++) dec_tab[i] = 7'b1111111;
    end

    function automatic logic [6:0] ref_seg(input logic [15:0] v, input int i);
        logic [15:0] sh;
        sh = v >> (4 * i);
`ifdef SEVSEG_LZ_BLANK_EN
        if (i > 0 && sh == 16'h0) return 7'b1111111;
`endif
        return dec_tab[sh[3:0]];
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        t        = 0;
        act_v    = '0;
        act_dp   = '0;
        pend_v   = '0;
        pend_dp  = '0;
        pend_vld = 1'b0;
    endtask

    // Drives one cycle of inputs and queues what the outputs must show after the coming edge.
    task automatic apply_stimulus(input logic e, input logic l, input logic [15:0] v, input logic [3:0] d);
        exp_t x;
        int   slot;
        logic boundary;
        @(negedge clk);
        en    = e;
        load  = l;
        value = v;
        dp_in = d;
        slot  = (t / DIV) % N;
        if (e) begin
            x.seg = ref_seg(act_v, slot);
            x.dp  = ~act_dp[slot];
            x.an  = 4'hF;
            x.an[slot] = 1'b0;
        end else begin
            x.seg = 7'b1111111;
            x.dp  = 1'b1;
            x.an  = 4'hF;
        end
        boundary = e && ((t % FRAME) == FRAME - 1);
        x.ack    = 1'b0;
        if (boundary && l) begin
            act_v = v; act_dp = d; pend_vld = 1'b0; x.ack = 1'b1;
        end else begin
            if (boundary && pend_vld) begin
                act_v = pend_v; act_dp = pend_dp; pend_vld = 1'b0; x.ack = 1'b1;
            end
            if (l) begin
                pend_v = v; pend_dp = d; pend_vld = 1'b1;
            end
        end
        if (e) t++;
        sb.push_back(x);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 16'h0, 4'h0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check_output("seg", 32'(seg), 32'(mon_e.seg));
            check_output("dp", 32'(dp), 32'(mon_e.dp));
            check_output("an", 32'(an), 32'(mon_e.an));
            check_output("load_ack", 32'(load_ack), 32'(mon_e.ack));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_seg"}, 32'(seg), 32'h7F);
        check_output({tag, "_dp"}, 32'(dp), 32'h1);
        check_output({tag, "_an"}, 32'(an), 32'hF);
        check_output({tag, "_ack"}, 32'(load_ack), 32'h0);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        value = '0;
        dp_in = '0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Plain scan of 1234 with its ack after the first boundary.
        apply_stimulus(1'b1, 1'b1, 16'h1234, 4'h0);
        run_idle(2 * FRAME);

        // Two loads inside one frame: the later one wins, one ack.
        run_idle(3);
        apply_stimulus(1'b1, 1'b1, 16'h1111, 4'h2);
        run_idle(2);
        apply_stimulus(1'b1, 1'b1, 16'h2222, 4'h5);
        run_idle(2 * FRAME);

        // Load exactly on the boundary cycle goes straight to active.
        for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) run_idle(1);
        apply_stimulus(1'b1, 1'b1, 16'h0909, 4'h8);
        run_idle(2 * FRAME);

        // Enable dropped mid-digit for 10 cycles, with a load accepted meanwhile.
        run_idle(5);
        for (int i = 0; i < 10; i++)
            apply_stimulus(1'b0, (i == 4), 16'h5678, 4'h1);
        run_idle(2 * FRAME);

        // Leading-zero candidates and a non-BCD nibble.
        apply_stimulus(1'b1, 1'b1, 16'h0070, 4'hC);
        run_idle(2 * FRAME);
        apply_stimulus(1'b1, 1'b1, 16'h0000, 4'h0);
        run_idle(2 * FRAME);
        apply_stimulus(1'b1, 1'b1, 16'h0A00, 4'h0);
        run_idle(2 * FRAME);

        // Randomized traffic: mostly enabled, sporadic loads with any nibble value.
        for (int i = 0; i < 400; i++)
            apply_stimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                           16'($urandom), 4'($urandom));

        // Asynchronous reset mid-scan, seen without any clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        en   = 1'b0;
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_idle(2 * FRAME);

        @(posedge clk);
        #3;
        check_output("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
